branch_target_buffer: RTL

- Parametrised successor to the fetch-stage branch predictor.
- Tagged, direct-mapped BTB with N-bit saturating counters, plus a circular return-address stack (RAS) for jal/jr $31.
- Sits beside the PC mux in fetch and is looked up combinationally with imemaddr.
- Updated from the MEM stage when a branch resolves; RAS is pushed on jal and popped on jr $31 from decode.

---
 rtl/btb_pkg.sv | 48 ++++
 rtl/return_stack.sv | 62 ++++++
 rtl/branch_target_buffer.sv | 94 +++++++++
 3 files changed

// File: rtl/btb_pkg.sv
// Shared types and helpers for the fetch-stage branch target buffer.
// Entry fields are sized for the widest supported configuration; unused upper bits stay zero.
package btb_pkg;

  localparam int unsigned TAG_MAX_W = 30;
  localparam int unsigned CNT_MAX_W = 8;

  typedef logic [TAG_MAX_W-1:0] tag_t;
  typedef logic [CNT_MAX_W-1:0] cnt_t;

  typedef struct packed {
    logic        valid;
    tag_t        tag;
    logic [31:0] target;
    cnt_t        cnt;
  } btb_entry_t;

  // Weakly-not-taken: 0 followed by ones.
  function automatic cnt_t cnt_wnt(input int unsigned cnt_bits);
    cnt_t one;
    one = cnt_t'(1);
    return (one << (cnt_bits - 1)) - one;
  endfunction

  // Weakly-taken: 1 followed by zeros.
  function automatic cnt_t cnt_wt(input int unsigned cnt_bits);
    cnt_t one;
    one = cnt_t'(1);
    return one << (cnt_bits - 1);
  endfunction

  function automatic cnt_t cnt_max(input int unsigned cnt_bits);
    cnt_t one;
    one = cnt_t'(1);
    return (one << cnt_bits) - one;
  endfunction

  function automatic logic [31:0] pc_index(input logic [31:0] pc, input int unsigned idx_w);
    return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic tag_t pc_tag(input logic [31:0] pc, input int unsigned idx_w);
    logic [31:0] t;
    t = pc >> (idx_w + 2);
    return tag_t'(t);
  endfunction

endpackage

// File: rtl/return_stack.sv
// Circular return-address stack; the oldest entry is overwritten on overflow.
module return_stack
  import btb_pkg::*;
#(
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  logic [31:0] push_addr_i,
  input  logic        pop_i,
  output logic [31:0] top_o,
  output logic        empty_o
);

  localparam int unsigned SP_W  = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = SP_W + 1;

  logic [31:0]      mem_q [RAS_DEPTH];
  logic [SP_W-1:0]  sp_q, sp_d, sp_m1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_en;
  logic [SP_W-1:0]  wr_idx;

  assign sp_m1   = sp_q - SP_W'(1);
  assign empty_o = (cnt_q == '0);
  assign top_o   = empty_o ? '0 : mem_q[sp_m1];

  always_comb begin
    sp_d   = sp_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = sp_q;
    // Push+pop on a non-empty stack replaces the top in place.
    if (push_i && pop_i && !empty_o) begin
      wr_en  = 1'b1;
      wr_idx = sp_m1;
    end else if (push_i) begin
      wr_en  = 1'b1;
      sp_d   = sp_q + SP_W'(1);
      if (cnt_q != CNT_W'(RAS_DEPTH)) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop_i && !empty_o) begin
      sp_d  = sp_m1;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sp_q  <= '0;
      cnt_q <= '0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && wr_en) mem_q[wr_idx] <= push_addr_i;
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped tagged BTB with saturating counters plus a return-address stack.
// Lookup is combinational; updates from MEM commit on the clock edge without bypass.
module branch_target_buffer
  import btb_pkg::*;
#(
  parameter int unsigned ENTRIES   = 16,
  parameter int unsigned CNT_BITS  = 2,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic [31:0]                 lookup_pc,
  output logic                        pred_hit,
  output logic                        pred_taken,
  output logic [31:0]                 pred_target,
  output logic [$clog2(ENTRIES)-1:0]  pred_index,
  input  logic                        upd_valid,
  input  logic [31:0]                 upd_pc,
  input  logic                        upd_taken,
  input  logic [31:0]                 upd_target,
  input  logic                        ras_push,
  input  logic [31:0]                 ras_push_addr,
  input  logic                        ras_pop,
  output logic [31:0]                 ras_top,
  output logic                        ras_empty
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam cnt_t CNT_WNT = cnt_wnt(CNT_BITS);
  localparam cnt_t CNT_WT  = cnt_wt(CNT_BITS);
  localparam cnt_t CNT_SAT = cnt_max(CNT_BITS);
  localparam btb_entry_t RST_ENTRY = '{valid: 1'b0, tag: '0, target: '0, cnt: CNT_WNT};

  btb_entry_t       tbl_q [ENTRIES];
  btb_entry_t       lk_e, up_e, upd_entry_d;
  logic [IDX_W-1:0] lk_idx, up_idx;
  tag_t             lk_tag, up_tag;
  logic             up_hit, upd_we;

  assign lk_idx = IDX_W'(pc_index(lookup_pc, IDX_W));
  assign lk_tag = pc_tag(lookup_pc, IDX_W);
  assign lk_e   = tbl_q[lk_idx];

  assign pred_hit    = lk_e.valid && (lk_e.tag == lk_tag);
  assign pred_taken  = pred_hit && lk_e.cnt[CNT_BITS-1];
  assign pred_target = pred_hit ? lk_e.target : '0;
  assign pred_index  = lk_idx;

  assign up_idx = IDX_W'(pc_index(upd_pc, IDX_W));
  assign up_tag = pc_tag(upd_pc, IDX_W);
  assign up_e   = tbl_q[up_idx];
  assign up_hit = up_e.valid && (up_e.tag == up_tag);

  always_comb begin
    upd_we      = 1'b0;
    upd_entry_d = up_e;
    if (upd_valid) begin
      if (up_hit) begin
        upd_we = 1'b1;
        if (upd_taken) begin
          upd_entry_d.target = upd_target;
          if (up_e.cnt != CNT_SAT) upd_entry_d.cnt = up_e.cnt + cnt_t'(1);
        end else if (up_e.cnt != '0) begin
          upd_entry_d.cnt = up_e.cnt - cnt_t'(1);
        end
      end else if (upd_taken) begin
        // Taken miss evicts whatever occupies the slot.
        upd_we      = 1'b1;
        upd_entry_d = '{valid: 1'b1, tag: up_tag, target: upd_target, cnt: CNT_WT};
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int unsigned i = 0; i < ENTRIES; i++) tbl_q[i] <= RST_ENTRY;
    end else if (upd_we) begin
      tbl_q[up_idx] <= upd_entry_d;
    end
  end

  return_stack #(
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk_i      (CLK),
    .rst_ni     (nRST),
    .push_i     (ras_push),
    .push_addr_i(ras_push_addr),
    .pop_i      (ras_pop),
    .top_o      (ras_top),
    .empty_o    (ras_empty)
  );

endmodule
